// File: rtl/mimo_frame_scheduler.sv
// Frame sequencer for the 4x4 MIMO sphere detector: 4 R rows, a fixed gap, then Y vectors one at a time.
// Accepted beats reach det_* one cycle later; s_ready drops outside LOAD_R/SEND_Y and when no result slot is free.

// Result FIFO with a combinational head; push and pop may coincide when full.
module mimo_result_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [W-1:0]                 push_dat,
   input  logic                         pop_rdy,
   output logic                         pop_vld,
   output logic [W-1:0]                 pop_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign pop_vld = (count != '0);
   assign pop_dat = mem[rd_ptr];
   assign do_pop  = pop_rdy && pop_vld;
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module mimo_frame_scheduler #(
   parameter int WIDTH      = 16,
   parameter int SYM_PER_CH = 8,
   parameter int RES_DEPTH  = 4,
   parameter int Y_GAP      = 2,
   parameter int TIMEOUT    = 4095
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic               s_is_channel,
   input  logic [WIDTH*8-1:0] s_data,
   output logic               det_in_valid,
   output logic               det_flag,
   output logic [WIDTH*8-1:0] det_data,
   input  logic               det_in_ready,
   input  logic               det_out_valid,
   input  logic [11:0]        det_out_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [11:0]        m_data,
   output logic               busy,
   output logic               err_proto,
   output logic               err_timeout
);
   localparam int CW = $clog2(RES_DEPTH+1);
   localparam int TW = $clog2(TIMEOUT+1);
   localparam int GW = (Y_GAP > 1) ? $clog2(Y_GAP) : 1;
   localparam logic [GW-1:0] G_LAST = GW'(Y_GAP - 1);
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
   localparam logic [7:0]    Y_LAST = 8'(SYM_PER_CH - 1);
   localparam logic [CW-1:0] FULL   = CW'(RES_DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD_R, GAP, SEND_Y, WAIT_DET, HALT} state_t;

   state_t          state, state_nxt;
   logic            first_frame;
   logic [1:0]      r_cnt;
   logic [GW-1:0]   g_cnt;
   logic [7:0]      y_cnt;
   logic [TW-1:0]   t_cnt;
   logic [CW-1:0]   fifo_count;
   logic            room;
   logic            fwd;
   logic            drop;
   logic            push;
   logic            timeout_hit;

   // A free slot is all that is needed: only one Y is ever outstanding.
   assign room = (fifo_count < FULL);
   assign busy = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      s_ready     = 1'b0;
      fwd         = 1'b0;
      drop        = 1'b0;
      push        = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!first_frame || det_in_ready) state_nxt = LOAD_R;
         end
         LOAD_R: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (s_is_channel) begin
                  fwd = 1'b1;
                  if (r_cnt == 2'd3) state_nxt = GAP;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         GAP: begin
            if (g_cnt == G_LAST) state_nxt = SEND_Y;
         end
         SEND_Y: begin
            s_ready = room;
            if (s_valid && room) begin
               if (!s_is_channel) begin
                  fwd       = 1'b1;
                  state_nxt = WAIT_DET;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         WAIT_DET: begin
            if (det_out_valid) begin
               push      = 1'b1;
               state_nxt = (y_cnt == Y_LAST) ? LOAD_R : SEND_Y;
            end else if (t_cnt == T_MAX) begin
               timeout_hit = 1'b1;
               state_nxt   = HALT;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state        <= IDLE;
         first_frame  <= 1'b1;
         r_cnt        <= '0;
         g_cnt        <= '0;
         y_cnt        <= '0;
         t_cnt        <= '0;
         det_in_valid <= 1'b0;
         det_flag     <= 1'b0;
         det_data     <= '0;
         err_proto    <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         state        <= state_nxt;
         det_in_valid <= fwd;
         if (fwd) begin
            det_flag <= s_is_channel;
            det_data <= s_data;
         end
         if (drop)        err_proto   <= 1'b1;
         if (timeout_hit) err_timeout <= 1'b1;
         case (state)
            IDLE: r_cnt <= '0;
            LOAD_R: begin
               g_cnt <= '0;
               if (fwd) begin
                  r_cnt <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) first_frame <= 1'b0;
               end
            end
            GAP: begin
               g_cnt <= g_cnt + GW'(1);
               y_cnt <= '0;
            end
            SEND_Y: t_cnt <= '0;
            WAIT_DET: begin
               if (!timeout_hit) t_cnt <= t_cnt + TW'(1);
               if (push)         y_cnt <= y_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   mimo_result_fifo #(.W(12), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .push     (push),
      .push_dat (det_out_data),
      .pop_rdy  (m_ready),
      .pop_vld  (m_valid),
      .pop_dat  (m_data),
      .count    (fifo_count)
   );
endmodule
